// File: rtl/dmem_arb_pkg.sv
// Shared encodings for the data-memory arbiter: FSM states, owner tags, default widths.
package dmem_arb_pkg;
  localparam int ADDR_W_DEF = 8;
  localparam int DATA_W_DEF = 16;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_e;

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_ACC = 1'b1
  } owner_e;
endpackage

// File: rtl/dmem_arb_rr_arb2.sv
// Two-way round-robin picker; bit 0 = CPU, bit 1 = accelerator. One-hot grant.
module rr_arb2
  import dmem_arb_pkg::*;
(
  input  logic [1:0] req_i,
  input  owner_e     last_grant_i,
  input  logic       en_i,
  output logic [1:0] gnt_o
);
  always_comb begin
    gnt_o = 2'b00;
    if (en_i) begin
      if (&req_i) gnt_o = (last_grant_i == OWN_ACC) ? 2'b01 : 2'b10;
      else        gnt_o = req_i;
    end
  end
endmodule

// File: rtl/dmem_arbiter.sv
// Shares a single-port registered-read BRAM between the CPU Mem stage and the accelerator
// load/store engine, one transaction in flight, round-robin on ties.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_rd,
  input  logic              cpu_wr,
  input  logic [15:0]       cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  input  logic              acc_req,
  input  logic              acc_we,
  input  logic [15:0]       acc_addr,
  input  logic [DATA_W-1:0] acc_wdata,
  output logic [DATA_W-1:0] acc_rdata,
  output logic              acc_done,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_wren,
  input  logic [DATA_W-1:0] ram_q
);
  state_e            state_q, state_d;
  owner_e            owner_q, owner_d;
  owner_e            last_grant_q, last_grant_d;
  logic              is_wr_q, is_wr_d;
  logic              ram_wren_q, ram_wren_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;
  logic [DATA_W-1:0] cpu_rdata_q, acc_rdata_q;
  logic              cpu_req;
  logic [1:0]        gnt;

  // Upper address bits are intentionally ignored.
  logic unused_addr_hi;
  assign unused_addr_hi = ^{cpu_addr[15:ADDR_W], acc_addr[15:ADDR_W]};

  assign cpu_req = cpu_rd | cpu_wr;

  rr_arb2 u_arb (
    .req_i        ({acc_req, cpu_req}),
    .last_grant_i (last_grant_q),
    .en_i         (state_q == S_IDLE),
    .gnt_o        (gnt)
  );

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    is_wr_d      = is_wr_q;
    ram_addr_d   = ram_addr_q;
    ram_wdata_d  = ram_wdata_q;
    ram_wren_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (gnt[0]) begin
          state_d      = S_ISSUE;
          owner_d      = OWN_CPU;
          last_grant_d = OWN_CPU;
          is_wr_d      = cpu_wr;
          ram_addr_d   = cpu_addr[ADDR_W-1:0];
          ram_wdata_d  = cpu_wdata;
          ram_wren_d   = cpu_wr;
        end else if (gnt[1]) begin
          state_d      = S_ISSUE;
          owner_d      = OWN_ACC;
          last_grant_d = OWN_ACC;
          is_wr_d      = acc_we;
          ram_addr_d   = acc_addr[ADDR_W-1:0];
          ram_wdata_d  = acc_wdata;
          ram_wren_d   = acc_we;
        end
      end
      S_ISSUE: state_d = is_wr_q ? S_RESP : S_WAIT;
      S_WAIT:  state_d = S_RESP;
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      owner_q      <= OWN_CPU;
      last_grant_q <= OWN_ACC;
      is_wr_q      <= 1'b0;
      ram_wren_q   <= 1'b0;
      ram_addr_q   <= '0;
      ram_wdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      is_wr_q      <= is_wr_d;
      ram_wren_q   <= ram_wren_d;
      ram_addr_q   <= ram_addr_d;
      ram_wdata_q  <= ram_wdata_d;
    end
  end

  // BRAM output is valid during WAIT; reset takes priority so an aborted read never lands.
  always_ff @(posedge clk) begin
    if (rst) begin
      cpu_rdata_q <= '0;
      acc_rdata_q <= '0;
    end else if (state_q == S_WAIT) begin
      if (owner_q == OWN_CPU) cpu_rdata_q <= ram_q;
      else                    acc_rdata_q <= ram_q;
    end
  end

  assign cpu_stall = cpu_req & ~((state_q == S_RESP) & (owner_q == OWN_CPU));
  assign acc_done  = (state_q == S_RESP) & (owner_q == OWN_ACC);
  assign cpu_rdata = cpu_rdata_q;
  assign acc_rdata = acc_rdata_q;
  assign ram_addr  = ram_addr_q;
  assign ram_wdata = ram_wdata_q;
  assign ram_wren  = ram_wren_q;
endmodule
